// File: rtl/multicycle_sequencer_pkg.sv
// Shared encodings for the multicycle sequencer: states, instruction classes,
// opcode constants and ALU operand-B select codes.
package multicycle_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_MEMORY    = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_HALT      = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        CLS_R       = 3'd0,
        CLS_I       = 3'd1,
        CLS_LOAD    = 3'd2,
        CLS_STORE   = 3'd3,
        CLS_SYSTEM  = 3'd4,
        CLS_ILLEGAL = 3'd5
    } class_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [1:0] ALU_SRC_B_RS2   = 2'b00;
    localparam logic [1:0] ALU_SRC_B_FOUR  = 2'b01;
    localparam logic [1:0] ALU_SRC_B_IMM   = 2'b10;

endpackage

// File: rtl/multicycle_sequencer_opcode_classifier.sv
// Combinational opcode-to-class mapping; also shared with the instruction decoder.
module opcode_classifier
    import multicycle_sequencer_pkg::*;
(
    input  logic [6:0] opcode,
    output class_e     op_class
);

    // NOTE: a default arm plus a full case keeps this purely combinational (no latch).
    always_comb begin
        op_class = CLS_ILLEGAL;
        case (opcode)
            OP_R:      op_class = CLS_R;
            OP_I:      op_class = CLS_I;
            OP_LOAD:   op_class = CLS_LOAD;
            OP_STORE:  op_class = CLS_STORE;
            OP_SYSTEM: op_class = CLS_SYSTEM;
            default:   op_class = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_sequencer.sv
// Control FSM stepping the multicycle core through fetch/decode/execute/memory/
// writeback, with memory ready handshakes, sticky halt and a retire counter.
module multicycle_sequencer
    import multicycle_sequencer_pkg::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [6:0]           opcode,
    input  logic                 imem_ready,
    input  logic                 dmem_ready,
    output logic                 imem_rd_ena,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic                 alu_override,
    output logic                 alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic                 dmem_rd_ena,
    output logic                 dmem_wr_ena,
    output logic                 reg_file_write,
    output logic                 reg_file_write_src,
    output logic                 halted,
    output logic                 instr_retired,
    output logic [CNT_WIDTH-1:0] instr_count
);

    state_e                 state_q, state_d;
    class_e                 class_q, class_d;
    class_e                 dec_class;
    logic [CNT_WIDTH-1:0]   count_q, count_d;
    logic                   retire;

    opcode_classifier u_classifier (
        .opcode   (opcode),
        .op_class (dec_class)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours; reset here is synchronous.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FETCH;
            class_q <= CLS_R;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            class_q <= class_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d            = state_q;
        class_d            = class_q;
        retire             = 1'b0;
        imem_rd_ena        = 1'b0;
        ir_write           = 1'b0;
        pc_write           = 1'b0;
        alu_override       = 1'b0;
        alu_src_a          = 1'b0;
        alu_src_b          = ALU_SRC_B_RS2;
        dmem_rd_ena        = 1'b0;
        dmem_wr_ena        = 1'b0;
        reg_file_write     = 1'b0;
        reg_file_write_src = 1'b0;
        halted             = 1'b0;

        case (state_q)
            ST_FETCH: begin
                imem_rd_ena  = 1'b1;
                alu_src_a    = 1'b0;
                alu_src_b    = ALU_SRC_B_FOUR;
                alu_override = 1'b1;
                ir_write     = imem_ready;
                if (imem_ready) state_d = ST_DECODE;
            end
            ST_DECODE: begin
                // PC advances even for an instruction that is about to halt.
                pc_write = 1'b1;
                class_d  = dec_class;
                if (dec_class == CLS_SYSTEM || dec_class == CLS_ILLEGAL) state_d = ST_HALT;
                else                                                     state_d = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                alu_src_a = 1'b1;
                case (class_q)
                    CLS_R: begin
                        alu_src_b = ALU_SRC_B_RS2;
                        state_d   = ST_WRITEBACK;
                    end
                    CLS_I: begin
                        alu_src_b = ALU_SRC_B_IMM;
                        state_d   = ST_WRITEBACK;
                    end
                    CLS_LOAD, CLS_STORE: begin
                        alu_src_b    = ALU_SRC_B_IMM;
                        alu_override = 1'b1;
                        state_d      = ST_MEMORY;
                    end
                    default: state_d = ST_HALT;
                endcase
            end
            ST_MEMORY: begin
                dmem_rd_ena = (class_q == CLS_LOAD);
                dmem_wr_ena = (class_q == CLS_STORE);
                if (dmem_ready) begin
                    if (class_q == CLS_LOAD) begin
                        state_d = ST_WRITEBACK;
                    end else begin
                        state_d = ST_FETCH;
                        retire  = 1'b1;
                    end
                end
            end
            ST_WRITEBACK: begin
                reg_file_write     = 1'b1;
                reg_file_write_src = (class_q != CLS_LOAD);
                retire             = 1'b1;
                state_d            = ST_FETCH;
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: state_d = ST_FETCH;
        endcase

        // Reset abandons the instruction in flight: no memory traffic, no writes, no retire.
        if (rst) begin
            imem_rd_ena    = 1'b0;
            ir_write       = 1'b0;
            pc_write       = 1'b0;
            dmem_rd_ena    = 1'b0;
            dmem_wr_ena    = 1'b0;
            reg_file_write = 1'b0;
            retire         = 1'b0;
        end

        count_d = count_q + {{(CNT_WIDTH-1){1'b0}}, retire};
    end

    assign instr_retired = retire;
    assign instr_count   = count_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed self-checking bench for multicycle_sequencer; expected output vectors
// are queued as each step is driven and compared at the following falling edge.
module tb_multicycle_sequencer;

    localparam logic [6:0] T_R      = 7'b0110011;
    localparam logic [6:0] T_I      = 7'b0010011;
    localparam logic [6:0] T_LOAD   = 7'b0000011;
    localparam logic [6:0] T_STORE  = 7'b0100011;
    localparam logic [6:0] T_ECALL  = 7'b1110011;
    localparam logic [6:0] T_BAD    = 7'b1111111;

    typedef struct packed {
        logic       imem_rd;
        logic       ir_w;
        logic       pc_w;
        logic       alu_ovr;
        logic       src_a;
        logic [1:0] src_b;
        logic       dmem_rd;
        logic       dmem_wr;
        logic       rf_w;
        logic       rf_src;
        logic       halted;
        logic       retired;
    } outv_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  opcode;
    logic        imem_ready;
    logic        dmem_ready;

    logic        imem_rd_ena, ir_write, pc_write, alu_override, alu_src_a;
    logic [1:0]  alu_src_b;
    logic        dmem_rd_ena, dmem_wr_ena, reg_file_write, reg_file_write_src;
    logic        halted, instr_retired;
    logic [31:0] instr_count;

    logic        w_imem_rd_ena, w_ir_write, w_pc_write, w_alu_override, w_alu_src_a;
    logic [1:0]  w_alu_src_b;
    logic        w_dmem_rd_ena, w_dmem_wr_ena, w_reg_file_write, w_reg_file_write_src;
    logic        w_halted, w_instr_retired;
    logic [3:0]  w_instr_count;

    outv_t       sb_q[$];
    string       tag_q[$];
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    multicycle_sequencer #(.CNT_WIDTH(32)) u_dut (
        .clk                (clk),
        .rst                (rst),
        .opcode             (opcode),
        .imem_ready         (imem_ready),
        .dmem_ready         (dmem_ready),
        .imem_rd_ena        (imem_rd_ena),
        .ir_write           (ir_write),
        .pc_write           (pc_write),
        .alu_override       (alu_override),
        .alu_src_a          (alu_src_a),
        .alu_src_b          (alu_src_b),
        .dmem_rd_ena        (dmem_rd_ena),
        .dmem_wr_ena        (dmem_wr_ena),
        .reg_file_write     (reg_file_write),
        .reg_file_write_src (reg_file_write_src),
        .halted             (halted),
        .instr_retired      (instr_retired),
        .instr_count        (instr_count)
    );

    multicycle_sequencer #(.CNT_WIDTH(4)) u_dut_w4 (
        .clk                (clk),
        .rst                (rst),
        .opcode             (opcode),
        .imem_ready         (imem_ready),
        .dmem_ready         (dmem_ready),
        .imem_rd_ena        (w_imem_rd_ena),
        .ir_write           (w_ir_write),
        .pc_write           (w_pc_write),
        .alu_override       (w_alu_override),
        .alu_src_a          (w_alu_src_a),
        .alu_src_b          (w_alu_src_b),
        .dmem_rd_ena        (w_dmem_rd_ena),
        .dmem_wr_ena        (w_dmem_wr_ena),
        .reg_file_write     (w_reg_file_write),
        .reg_file_write_src (w_reg_file_write_src),
        .halted             (w_halted),
        .instr_retired      (w_instr_retired),
        .instr_count        (w_instr_count)
    );

    function automatic outv_t v_rst_fetch();
        outv_t v = '0;
        v.alu_ovr = 1'b1;
        v.src_b   = 2'b01;
        return v;
    endfunction

    function automatic outv_t v_fetch(input logic ir);
        outv_t v = '0;
        v.imem_rd = 1'b1;
        v.ir_w    = ir;
        v.alu_ovr = 1'b1;
        v.src_b   = 2'b01;
        return v;
    endfunction

    function automatic outv_t v_decode();
        outv_t v = '0;
        v.pc_w = 1'b1;
        return v;
    endfunction

    function automatic outv_t v_exec(input logic r_type, input logic mem);
        outv_t v = '0;
        v.src_a   = 1'b1;
        v.src_b   = r_type ? 2'b00 : 2'b10;
        v.alu_ovr = mem;
        return v;
    endfunction

    function automatic outv_t v_mem(input logic is_load, input logic rdy);
        outv_t v = '0;
        v.dmem_rd = is_load;
        v.dmem_wr = !is_load;
        v.retired = !is_load && rdy;
        return v;
    endfunction

    function automatic outv_t v_wb(input logic src);
        outv_t v = '0;
        v.rf_w    = 1'b1;
        v.rf_src  = src;
        v.retired = 1'b1;
        return v;
    endfunction

    function automatic outv_t v_halt();
        outv_t v = '0;
        v.halted = 1'b1;
        return v;
    endfunction

    task automatic step(input logic r, input logic [6:0] op, input logic ir_rdy,
                        input logic dm_rdy, input outv_t exp, input string tag);
        outv_t obs, e;
        string t;
        rst        = r;
        opcode     = op;
        imem_ready = ir_rdy;
        dmem_ready = dm_rdy;
        sb_q.push_back(exp);
        tag_q.push_back(tag);
        @(negedge clk);
        obs = '{imem_rd_ena, ir_write, pc_write, alu_override, alu_src_a, alu_src_b,
                dmem_rd_ena, dmem_wr_ena, reg_file_write, reg_file_write_src,
                halted, instr_retired};
        e = sb_q.pop_front();
        t = tag_q.pop_front();
        n_cmp++;
        assert (obs === e) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", t, obs, e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_cnt(input logic [31:0] e32, input logic [3:0] e4, input string tag);
        n_cmp++;
        assert (instr_count === e32) else begin
            n_err++;
            $error("FAIL %s count32: observed %0d expected %0d", tag, instr_count, e32);
        end
        n_cmp++;
        assert (w_instr_count === e4) else begin
            n_err++;
            $error("FAIL %s count4: observed %0d expected %0d", tag, w_instr_count, e4);
        end
    endtask

    task automatic run_alu(input logic [6:0] op, input logic r_type, input string tag);
        step(1'b0, op, 1'b1, 1'b1, v_fetch(1'b1), {tag, "_fetch"});
        step(1'b0, op, 1'b1, 1'b1, v_decode(), {tag, "_decode"});
        step(1'b0, op, 1'b1, 1'b1, v_exec(r_type, 1'b0), {tag, "_exec"});
        step(1'b0, op, 1'b1, 1'b1, v_wb(1'b1), {tag, "_wb"});
    endtask

    initial begin
        rst        = 1'b1;
        opcode     = T_R;
        imem_ready = 1'b1;
        dmem_ready = 1'b1;
        @(posedge clk);
        #1;

        // Reset state, enables forced low while rst is held.
        step(1'b1, T_R, 1'b1, 1'b1, v_rst_fetch(), "reset_0");
        step(1'b1, T_R, 1'b1, 1'b1, v_rst_fetch(), "reset_1");
        check_cnt(32'd0, 4'd0, "after_reset");

        // R-type, zero wait states.
        run_alu(T_R, 1'b1, "r0");
        check_cnt(32'd1, 4'd1, "after_r0");

        // LOAD with dmem_ready low for three MEMORY cycles.
        step(1'b0, T_BAD,  1'b1, 1'b0, v_fetch(1'b1), "ld_fetch");
        step(1'b0, T_LOAD, 1'b1, 1'b0, v_decode(), "ld_decode");
        step(1'b0, T_BAD,  1'b0, 1'b0, v_exec(1'b0, 1'b1), "ld_exec");
        for (int i = 0; i < 3; i++)
            step(1'b0, T_BAD, 1'b1, 1'b0, v_mem(1'b1, 1'b0), "ld_mem_wait");
        step(1'b0, T_BAD, 1'b1, 1'b1, v_mem(1'b1, 1'b1), "ld_mem_ready");
        step(1'b0, T_BAD, 1'b1, 1'b1, v_wb(1'b0), "ld_wb");
        check_cnt(32'd2, 4'd2, "after_load");

        // STORE with imem_ready low for two FETCH cycles.
        step(1'b0, T_R, 1'b0, 1'b1, v_fetch(1'b0), "st_fetch_wait0");
        step(1'b0, T_R, 1'b0, 1'b1, v_fetch(1'b0), "st_fetch_wait1");
        step(1'b0, T_R, 1'b1, 1'b1, v_fetch(1'b1), "st_fetch_ready");
        step(1'b0, T_STORE, 1'b0, 1'b1, v_decode(), "st_decode");
        step(1'b0, T_R, 1'b0, 1'b1, v_exec(1'b0, 1'b1), "st_exec");
        step(1'b0, T_R, 1'b0, 1'b1, v_mem(1'b0, 1'b1), "st_mem");
        check_cnt(32'd3, 4'd3, "after_store");

        // I-type.
        run_alu(T_I, 1'b0, "i0");
        check_cnt(32'd4, 4'd4, "after_i0");

        // Reset during MEMORY of a LOAD: read enable drops at once, no retire.
        step(1'b0, T_LOAD, 1'b1, 1'b0, v_fetch(1'b1), "rl_fetch");
        step(1'b0, T_LOAD, 1'b1, 1'b0, v_decode(), "rl_decode");
        step(1'b0, T_LOAD, 1'b1, 1'b0, v_exec(1'b0, 1'b1), "rl_exec");
        step(1'b0, T_LOAD, 1'b1, 1'b0, v_mem(1'b1, 1'b0), "rl_mem");
        step(1'b1, T_LOAD, 1'b1, 1'b1, outv_t'('0), "rl_mem_in_reset");
        check_cnt(32'd0, 4'd0, "after_mid_reset");
        step(1'b0, T_R, 1'b1, 1'b1, v_fetch(1'b1), "rl_back_in_fetch");
        step(1'b0, T_R, 1'b1, 1'b1, v_decode(), "r1_decode");
        step(1'b0, T_R, 1'b1, 1'b1, v_exec(1'b1, 1'b0), "r1_exec");
        step(1'b0, T_R, 1'b1, 1'b1, v_wb(1'b1), "r1_wb");
        check_cnt(32'd1, 4'd1, "after_r1");

        // Illegal opcode halts; opcode and ready changes have no effect.
        step(1'b0, T_BAD, 1'b1, 1'b1, v_fetch(1'b1), "ill_fetch");
        step(1'b0, T_BAD, 1'b1, 1'b1, v_decode(), "ill_decode");
        for (int i = 0; i < 20; i++)
            step(1'b0, 7'($urandom), 1'($urandom), 1'($urandom), v_halt(), "ill_halt");
        check_cnt(32'd1, 4'd1, "after_illegal_halt");

        // ECALL after a reset also halts.
        step(1'b1, T_ECALL, 1'b1, 1'b1, v_halt(), "halt_in_reset");
        step(1'b1, T_ECALL, 1'b1, 1'b1, v_rst_fetch(), "ecall_reset");
        step(1'b0, T_ECALL, 1'b1, 1'b1, v_fetch(1'b1), "ecall_fetch");
        step(1'b0, T_ECALL, 1'b1, 1'b1, v_decode(), "ecall_decode");
        for (int i = 0; i < 20; i++)
            step(1'b0, (i % 2 == 0) ? T_R : T_LOAD, 1'b1, 1'b1, v_halt(), "ecall_halt");
        check_cnt(32'd0, 4'd0, "after_ecall_halt");

        // 17 back-to-back I-types: the 4-bit counter wraps to 1.
        step(1'b1, T_I, 1'b1, 1'b1, v_halt(), "wrap_reset_from_halt");
        step(1'b1, T_I, 1'b1, 1'b1, v_rst_fetch(), "wrap_reset");
        for (int i = 0; i < 17; i++)
            run_alu(T_I, 1'b0, "wrap_i");
        check_cnt(32'd17, 4'd1, "after_wrap");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
